can_frame_decoder: RTL and testbench

Bit-level CAN 2.0A/2.0B receive decoder: consumes one already-destuffed bus bit per `sample` rising edge and classifies the traffic as data, remote, error or overload frames. It extracts ID, DLC and data, checks the CRC-15, and reports CRC/ACK/EOF delimiter form errors. It sits after the bit-timing/destuff stage and feeds the receive buffer and monitoring logic.

---
 rtl/can_frame_decoder_pkg.sv | 45 ++++
 rtl/can_frame_decoder_crc15.sv | 28 ++
 rtl/can_frame_decoder.sv | 333 +++++++++++++++++++++++++++++++++
 tb/tb_can_frame_decoder.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/can_frame_decoder_pkg.sv
// Shared definitions for the CAN receive decoder: state codes, field lengths
// and the CRC-15 step used by the checker.
package can_frame_decoder_pkg;

   localparam logic [14:0] CRC_POLY = 15'h4599;

   localparam int ID_A_LEN  = 11;
   localparam int ID_B_LEN  = 18;
   localparam int DLC_LEN   = 4;
   localparam int CRC_LEN   = 15;
   localparam int EOF_LEN   = 7;
   localparam int DELIM_LEN = 8;
   localparam int FLAG_LEN  = 6;
   localparam int TAIL_LEN  = 7;
   localparam int IMF_LEN   = 3;
   localparam int OVL_LEN   = 13;

   typedef enum logic [6:0] {
      ST_IDLE         = 7'd0,
      ST_ID_A         = 7'd1,
      ST_CTRL_A       = 7'd2,
      ST_R0           = 7'd3,
      ST_ID_B         = 7'd4,
      ST_CTRL_B       = 7'd5,
      ST_DLC          = 7'd6,
      ST_DATA         = 7'd7,
      ST_CRC          = 7'd8,
      ST_CRC_DEL      = 7'd9,
      ST_ACK_SLOT     = 7'd10,
      ST_ACK_DEL      = 7'd11,
      ST_EOF          = 7'd12,
      ST_INTERMISSION = 7'd13,
      ST_ERR_FLAG     = 7'd14,
      ST_FLAG_TAIL    = 7'd15,
      ST_OVL_WAIT     = 7'd16,
      ST_DELIM        = 7'd17
   } state_e;

   function automatic logic [14:0] crc15_step(input logic [14:0] crc, input logic b);
      logic fb;
      fb = b ^ crc[14];
      crc15_step = {crc[13:0], 1'b0} ^ (fb ? CRC_POLY : 15'h0000);
   endfunction

endpackage

// File: rtl/can_frame_decoder_crc15.sv
// Serial CRC-15 register: clear loads the first bit onto a zero register,
// enable shifts one bit per sample edge, otherwise the value holds.
module can_crc15
   import can_frame_decoder_pkg::*;
(
   input  logic        clock,
   input  logic        reset_n,
   input  logic        clear,
   input  logic        enable,
   input  logic        bit_in,
   output logic [14:0] crc
);

   logic [14:0] crc_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         crc_q <= '0;
      end else if (clear) begin
         crc_q <= crc15_step(15'h0000, bit_in);
      end else if (enable) begin
         crc_q <= crc15_step(crc_q, bit_in);
      end
   end

   assign crc = crc_q;

endmodule

// File: rtl/can_frame_decoder.sv
// CAN 2.0A/2.0B receive decoder on a destuffed bit stream: classifies frames,
// extracts ID/DLC/data, checks CRC-15 and reports delimiter form errors.
module can_frame_decoder
   import can_frame_decoder_pkg::*;
(
   input  logic        sample,
   input  logic        reset_n,
   input  logic        can_data_bit,
   output logic        frame_data,
   output logic        frame_remote,
   output logic        frame_error,
   output logic        frame_overload,
   output logic        getframe,
   output logic        error_type,
   output logic        ack_error,
   output logic        crc_error,
   output logic        eof_error,
   output logic        crc_match,
   output logic [14:0] crcout,
   output logic        crcclk,
   output logic        start_crc,
   output logic        getcrc,
   output logic [1:0]  bit_classifier,
   output logic [10:0] bit_id_11,
   output logic [28:0] bit_id_29,
   output logic [3:0]  nbytes,
   output logic [63:0] can_data,
   output logic [5:0]  error_frame,
   output logic [6:0]  error_flag,
   output logic [12:0] overload_check,
   output logic [6:0]  debug_state
);

   localparam logic [5:0] PROBE_LAST = 6'(FLAG_LEN - 2);
   localparam logic [5:0] ID_A_LAST  = 6'(ID_A_LEN - 1);
   localparam logic [5:0] ID_B_LAST  = 6'(ID_B_LEN - 1);
   localparam logic [5:0] DLC_LAST   = 6'(DLC_LEN - 1);
   localparam logic [5:0] CRC_LAST   = 6'(CRC_LEN - 1);
   localparam logic [5:0] EOF_LAST   = 6'(EOF_LEN - 1);
   localparam logic [5:0] FLAG_LAST  = 6'(FLAG_LEN - 1);
   localparam logic [5:0] TAIL_LAST  = 6'(TAIL_LEN - 1);
   localparam logic [5:0] DELIM_LAST = 6'(DELIM_LEN - 1);
   localparam logic [5:0] IMF_LAST   = 6'(IMF_LEN - 1);
   localparam logic [3:0] OVL_BITS   = 4'(OVL_LEN);
   localparam logic [3:0] OVL_START  = 4'(FLAG_LEN - 1);

   state_e      state_q;
   logic [5:0]  cnt_q, data_last_q;
   logic [3:0]  ocnt_q;
   logic        from_err_q;
   logic [13:0] rx_crc_q;
   logic [10:0] id_a_q;
   logic [17:0] id_b_q;
   logic [1:0]  cls_q;
   logic [3:0]  nbytes_q;
   logic [63:0] data_q;
   logic [5:0]  err_frame_q;
   logic [6:0]  err_flag_q;
   logic [12:0] ovl_q;
   logic [14:0] crcout_q;
   logic        frame_data_q, frame_remote_q, frame_error_q, frame_overload_q;
   logic        getframe_q, error_type_q, ack_error_q, crc_error_q, eof_error_q;
   logic        crc_match_q, crcclk_q, start_crc_q, getcrc_q;

   logic        start_crc_d, getcrc_d;
   logic [3:0]  dlc_w;
   logic [14:0] crc_w;

   // The CRC register must see the bit on the same edge it is sampled, so its
   // controls are decoded combinationally; the outputs are registered copies.
   always_comb begin
      start_crc_d = !can_data_bit && (state_q == ST_IDLE || state_q == ST_INTERMISSION);
      getcrc_d    = start_crc_d;
      case (state_q)
         ST_ID_A, ST_CTRL_A, ST_R0, ST_ID_B, ST_CTRL_B, ST_DLC, ST_DATA: getcrc_d = 1'b1;
         default: ;
      endcase
   end

   assign dlc_w = {nbytes_q[2:0], can_data_bit};

   can_crc15 u_crc (
      .clock   (sample),
      .reset_n (reset_n),
      .clear   (start_crc_d),
      .enable  (getcrc_d),
      .bit_in  (can_data_bit),
      .crc     (crc_w)
   );

   always_ff @(posedge sample or negedge reset_n) begin
      if (!reset_n) begin
         state_q          <= ST_IDLE;
         cnt_q            <= '0;
         data_last_q      <= '0;
         ocnt_q           <= '0;
         from_err_q       <= 1'b0;
         rx_crc_q         <= '0;
         id_a_q           <= '0;
         id_b_q           <= '0;
         cls_q            <= '0;
         nbytes_q         <= '0;
         data_q           <= '0;
         err_frame_q      <= '0;
         err_flag_q       <= '0;
         ovl_q            <= '0;
         crcout_q         <= '0;
         frame_data_q     <= 1'b0;
         frame_remote_q   <= 1'b0;
         frame_error_q    <= 1'b0;
         frame_overload_q <= 1'b0;
         getframe_q       <= 1'b0;
         error_type_q     <= 1'b0;
         ack_error_q      <= 1'b0;
         crc_error_q      <= 1'b0;
         eof_error_q      <= 1'b0;
         crc_match_q      <= 1'b0;
         crcclk_q         <= 1'b0;
         start_crc_q      <= 1'b0;
         getcrc_q         <= 1'b0;
      end else begin
         getframe_q  <= 1'b0;
         crcclk_q    <= 1'b0;
         start_crc_q <= start_crc_d;
         getcrc_q    <= getcrc_d;
         cnt_q       <= cnt_q + 6'd1;
         case (state_q)
            ST_IDLE, ST_INTERMISSION: begin
               if (!can_data_bit) begin
                  state_q          <= ST_ID_A;
                  cnt_q            <= '0;
                  from_err_q       <= 1'b0;
                  ocnt_q           <= '0;
                  id_a_q           <= '0;
                  id_b_q           <= '0;
                  cls_q            <= '0;
                  nbytes_q         <= '0;
                  data_q           <= '0;
                  err_frame_q      <= '0;
                  err_flag_q       <= '0;
                  ovl_q            <= '0;
                  frame_data_q     <= 1'b0;
                  frame_remote_q   <= 1'b0;
                  frame_error_q    <= 1'b0;
                  frame_overload_q <= 1'b0;
                  error_type_q     <= 1'b0;
                  ack_error_q      <= 1'b0;
                  crc_error_q      <= 1'b0;
                  eof_error_q      <= 1'b0;
                  crc_match_q      <= 1'b0;
               end else if (state_q == ST_INTERMISSION && cnt_q == IMF_LAST) begin
                  state_q <= ST_IDLE;
               end
            end
            ST_ID_A: begin
               id_a_q <= {id_a_q[9:0], can_data_bit};
               // Six dominant bits from SOF cannot be an identifier: it is a flag.
               if (cnt_q == PROBE_LAST && id_a_q[3:0] == 4'd0 && !can_data_bit) begin
                  state_q <= ST_FLAG_TAIL;
                  cnt_q   <= '0;
                  ovl_q   <= '0;
                  ocnt_q  <= OVL_START;
               end else if (cnt_q == ID_A_LAST) begin
                  state_q <= ST_CTRL_A;
                  cnt_q   <= '0;
               end
            end
            ST_CTRL_A: begin
               cls_q <= {cls_q[0], can_data_bit};
               if (cnt_q == 6'd1) begin
                  cnt_q <= '0;
                  if (can_data_bit) begin
                     state_q <= ST_ID_B;
                  end else begin
                     frame_data_q   <= ~cls_q[0];
                     frame_remote_q <= cls_q[0];
                     state_q        <= ST_R0;
                  end
               end
            end
            ST_R0: begin
               state_q <= ST_DLC;
               cnt_q   <= '0;
            end
            ST_ID_B: begin
               id_b_q <= {id_b_q[16:0], can_data_bit};
               if (cnt_q == ID_B_LAST) begin
                  state_q <= ST_CTRL_B;
                  cnt_q   <= '0;
               end
            end
            ST_CTRL_B: begin
               if (cnt_q == 6'd0) begin
                  frame_data_q   <= ~can_data_bit;
                  frame_remote_q <= can_data_bit;
               end else if (cnt_q == 6'd2) begin
                  state_q <= ST_DLC;
                  cnt_q   <= '0;
               end
            end
            ST_DLC: begin
               nbytes_q <= dlc_w;
               if (cnt_q == DLC_LAST) begin
                  cnt_q       <= '0;
                  data_last_q <= dlc_w[3] ? 6'd63 : {dlc_w[2:0] - 3'd1, 3'b111};
                  state_q     <= (frame_remote_q || dlc_w == 4'd0) ? ST_CRC : ST_DATA;
               end
            end
            ST_DATA: begin
               data_q <= {data_q[62:0], can_data_bit};
               if (cnt_q == data_last_q) begin
                  state_q <= ST_CRC;
                  cnt_q   <= '0;
               end
            end
            ST_CRC: begin
               rx_crc_q <= {rx_crc_q[12:0], can_data_bit};
               if (cnt_q == CRC_LAST) begin
                  crcclk_q    <= 1'b1;
                  crcout_q    <= crc_w;
                  crc_match_q <= (crc_w == {rx_crc_q, can_data_bit});
                  state_q     <= ST_CRC_DEL;
               end
            end
            ST_CRC_DEL: begin
               cnt_q       <= '0;
               crc_error_q <= !can_data_bit;
               state_q     <= can_data_bit ? ST_ACK_SLOT : ST_ERR_FLAG;
            end
            ST_ACK_SLOT: begin
               state_q <= ST_ACK_DEL;
            end
            ST_ACK_DEL: begin
               cnt_q       <= '0;
               ack_error_q <= !can_data_bit;
               state_q     <= can_data_bit ? ST_EOF : ST_ERR_FLAG;
            end
            ST_EOF: begin
               if (!can_data_bit) begin
                  eof_error_q <= 1'b1;
                  state_q     <= ST_ERR_FLAG;
                  cnt_q       <= '0;
               end else if (cnt_q == EOF_LAST) begin
                  getframe_q <= 1'b1;
                  state_q    <= ST_INTERMISSION;
                  cnt_q      <= '0;
               end
            end
            ST_ERR_FLAG: begin
               err_frame_q <= {err_frame_q[4:0], can_data_bit};
               if (cnt_q == FLAG_LAST) begin
                  error_type_q <= ~&{err_frame_q[4:0], can_data_bit};
                  from_err_q   <= 1'b1;
                  ovl_q        <= {8'd0, err_frame_q[3:0], can_data_bit};
                  ocnt_q       <= OVL_START;
                  state_q      <= ST_FLAG_TAIL;
                  cnt_q        <= '0;
               end
            end
            ST_FLAG_TAIL: begin
               err_flag_q <= {err_flag_q[5:0], can_data_bit};
               if (cnt_q == TAIL_LAST) begin
                  cnt_q <= '0;
                  if (&{err_flag_q[5:0], can_data_bit}) begin
                     state_q <= ST_OVL_WAIT;
                  end else begin
                     state_q <= ST_DELIM;
                     if (!from_err_q) error_type_q <= 1'b1;
                  end
               end
            end
            ST_OVL_WAIT: begin
               cnt_q <= '0;
               if (can_data_bit) begin
                  // After an error flag, eight recessive bits are its delimiter.
                  getframe_q       <= 1'b1;
                  frame_data_q     <= 1'b0;
                  frame_remote_q   <= 1'b0;
                  frame_error_q    <= from_err_q;
                  frame_overload_q <= ~from_err_q;
                  state_q          <= ST_IDLE;
               end else begin
                  state_q <= ST_DELIM;
                  if (!from_err_q) error_type_q <= 1'b1;
               end
            end
            ST_DELIM: begin
               if (!can_data_bit) begin
                  cnt_q <= '0;
               end else if (cnt_q == DELIM_LAST) begin
                  getframe_q       <= 1'b1;
                  frame_data_q     <= 1'b0;
                  frame_remote_q   <= 1'b0;
                  frame_error_q    <= 1'b1;
                  frame_overload_q <= 1'b0;
                  state_q          <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
         if ((state_q == ST_FLAG_TAIL || state_q == ST_OVL_WAIT || state_q == ST_DELIM)
             && ocnt_q < OVL_BITS) begin
            ovl_q  <= {ovl_q[11:0], can_data_bit};
            ocnt_q <= ocnt_q + 4'd1;
         end
      end
   end

   assign frame_data     = frame_data_q;
   assign frame_remote   = frame_remote_q;
   assign frame_error    = frame_error_q;
   assign frame_overload = frame_overload_q;
   assign getframe       = getframe_q;
   assign error_type     = error_type_q;
   assign ack_error      = ack_error_q;
   assign crc_error      = crc_error_q;
   assign eof_error      = eof_error_q;
   assign crc_match      = crc_match_q;
   assign crcout         = crcout_q;
   assign crcclk         = crcclk_q;
   assign start_crc      = start_crc_q;
   assign getcrc         = getcrc_q;
   assign bit_classifier = cls_q;
   assign bit_id_11      = id_a_q;
   assign bit_id_29      = {id_a_q, id_b_q};
   assign nbytes         = nbytes_q;
   assign can_data       = data_q;
   assign error_frame    = err_frame_q;
   assign error_flag     = err_flag_q;
   assign overload_check = ovl_q;
   assign debug_state    = state_q;

endmodule

// File: tb/tb_can_frame_decoder.sv
// Directed bench for can_frame_decoder: builds destuffed frames bit by bit,
// computes their CRC-15 independently and checks the decoded outputs.
module tb_can_frame_decoder;

   logic        sample = 1'b0;
   logic        reset_n;
   logic        can_data_bit;
   logic        frame_data, frame_remote, frame_error, frame_overload, getframe;
   logic        error_type, ack_error, crc_error, eof_error, crc_match, crcclk;
   logic        start_crc, getcrc;
   logic [14:0] crcout;
   logic [1:0]  bit_classifier;
   logic [10:0] bit_id_11;
   logic [28:0] bit_id_29;
   logic [3:0]  nbytes;
   logic [63:0] can_data;
   logic [5:0]  error_frame;
   logic [6:0]  error_flag;
   logic [12:0] overload_check;
   logic [6:0]  debug_state;

   can_frame_decoder dut (
      .sample(sample), .reset_n(reset_n), .can_data_bit(can_data_bit),
      .frame_data(frame_data), .frame_remote(frame_remote), .frame_error(frame_error),
      .frame_overload(frame_overload), .getframe(getframe), .error_type(error_type),
      .ack_error(ack_error), .crc_error(crc_error), .eof_error(eof_error),
      .crc_match(crc_match), .crcout(crcout), .crcclk(crcclk), .start_crc(start_crc),
      .getcrc(getcrc), .bit_classifier(bit_classifier), .bit_id_11(bit_id_11),
      .bit_id_29(bit_id_29), .nbytes(nbytes), .can_data(can_data),
      .error_frame(error_frame), .error_flag(error_flag),
      .overload_check(overload_check), .debug_state(debug_state)
   );

   always #5 sample = ~sample;

   int          checks = 0;
   int          errors = 0;
   logic        fbits[$];
   int          bit_idx, gf_count, gf_idx, cc_count, cc_idx, crc_last;
   logic        cc_match;
   logic [14:0] cc_crc, exp_crc;

   task automatic clear_mon();
      bit_idx = 0; gf_count = 0; gf_idx = -1; cc_count = 0; cc_idx = -1;
      cc_match = 1'b0; cc_crc = '0;
   endtask

   task automatic send_bit(input logic b);
      can_data_bit = b;
      @(posedge sample); #1;
      if (getframe === 1'b1) begin gf_count++; gf_idx = bit_idx; end
      if (crcclk === 1'b1) begin cc_count++; cc_idx = bit_idx; cc_match = crc_match; cc_crc = crcout; end
      bit_idx++;
   endtask

   task automatic send_range(input int first, input int last);
      for (int i = first; i <= last; i++) send_bit(fbits[i]);
   endtask

   task automatic push(input logic [63:0] v, input int w);
      for (int i = w - 1; i >= 0; i--) fbits.push_back(v[i]);
   endtask

   function automatic logic [14:0] model_crc(input int n);
      logic [14:0] c;
      logic        nx;
      c = '0;
      for (int i = 0; i < n; i++) begin
         nx = fbits[i] ^ c[14];
         c  = {c[13:0], 1'b0};
         if (nx) c = c ^ 15'h4599;
      end
      return c;
   endfunction

   task automatic build_frame(input logic ext, input logic [10:0] id11, input logic [17:0] id18,
                              input logic rtr, input logic [3:0] dlc, input logic [63:0] data,
                              input logic [14:0] crc_xor, input logic ack_del);
      int nb;
      fbits.delete();
      push(64'd0, 1);
      push(64'(id11), 11);
      if (!ext) begin
         push(64'(rtr), 1); push(64'd0, 1); push(64'd0, 1);
      end else begin
         push(64'd3, 2); push(64'(id18), 18); push(64'(rtr), 1); push(64'd0, 2);
      end
      push(64'(dlc), 4);
      nb = (dlc > 8) ? 8 : int'(dlc);
      if (!rtr) push(data, nb * 8);
      exp_crc = model_crc(fbits.size());
      push(64'(exp_crc ^ crc_xor), 15);
      crc_last = fbits.size() - 1;
      push(64'd1, 1); push(64'd0, 1); push(64'(ack_del), 1); push(64'h7F, 7);
   endtask

   task automatic test_reset();
      reset_n = 1'b0; can_data_bit = 1'b1;
      repeat (3) @(posedge sample);
      #1;
      checks++;
      if ({frame_data, frame_remote, frame_error, frame_overload, getframe, error_type, ack_error,
           crc_error, eof_error, crc_match, crcclk, start_crc, getcrc} !== 13'b0) begin
         errors++; $display("FAIL reset_flags: got %b want 0", {frame_data, frame_remote, frame_error,
            frame_overload, getframe, error_type, ack_error, crc_error, eof_error, crc_match, crcclk, start_crc, getcrc});
      end
      checks++;
      if ({bit_classifier, bit_id_29, nbytes, can_data, error_frame, error_flag, overload_check, crcout} !== '0) begin
         errors++; $display("FAIL reset_fields: got %h want 0",
            {bit_classifier, bit_id_29, nbytes, can_data, error_frame, error_flag, overload_check, crcout});
      end
      checks++;
      if (debug_state !== 7'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", debug_state); end
      reset_n = 1'b1;
      repeat (2) send_bit(1'b1);
   endtask

   task automatic test_std_data();
      clear_mon();
      build_frame(1'b0, 11'h551, 18'd0, 1'b0, 4'd4, 64'hABCD1234, 15'd0, 1'b1);
      send_range(0, fbits.size() - 1);
      checks++;
      if ({frame_data, frame_remote, frame_error, frame_overload} !== 4'b1000) begin
         errors++; $display("FAIL std_type: got %b want 1000", {frame_data, frame_remote, frame_error, frame_overload});
      end
      checks++;
      if (bit_id_11 !== 11'h551) begin errors++; $display("FAIL std_id: got %h want 551", bit_id_11); end
      checks++;
      if (nbytes !== 4'd4) begin errors++; $display("FAIL std_dlc: got %0d want 4", nbytes); end
      checks++;
      if (can_data !== 64'h00000000ABCD1234) begin errors++; $display("FAIL std_data: got %h want 00000000abcd1234", can_data); end
      checks++;
      if (cc_count !== 1 || cc_idx !== crc_last) begin
         errors++; $display("FAIL std_crcclk: got %0d pulses at bit %0d want 1 at bit %0d", cc_count, cc_idx, crc_last);
      end
      checks++;
      if (cc_match !== 1'b1 || cc_crc !== exp_crc) begin
         errors++; $display("FAIL std_crc: got match %b crc %h want match 1 crc %h", cc_match, cc_crc, exp_crc);
      end
      checks++;
      if (gf_count !== 1 || gf_idx !== fbits.size() - 1) begin
         errors++; $display("FAIL std_getframe: got %0d pulses at bit %0d want 1 at bit %0d", gf_count, gf_idx, fbits.size() - 1);
      end
      checks++;
      if ({ack_error, crc_error, eof_error, bit_classifier} !== 5'b0) begin
         errors++; $display("FAIL std_errs: got %b want 00000", {ack_error, crc_error, eof_error, bit_classifier});
      end
      repeat (3) send_bit(1'b1);
   endtask

   task automatic test_extended();
      clear_mon();
      build_frame(1'b1, 11'h7FF, 18'h3FFFF, 1'b0, 4'd8, 64'h9A07AA55FF00C2FE, 15'd0, 1'b1);
      send_range(0, fbits.size() - 1);
      checks++;
      if (bit_classifier !== 2'b11) begin errors++; $display("FAIL ext_class: got %b want 11", bit_classifier); end
      checks++;
      if (bit_id_29 !== 29'h1FFFFFFF) begin errors++; $display("FAIL ext_id: got %h want 1fffffff", bit_id_29); end
      checks++;
      if (can_data !== 64'h9A07AA55FF00C2FE || nbytes !== 4'd8) begin
         errors++; $display("FAIL ext_data: got %h dlc %0d want 9a07aa55ff00c2fe dlc 8", can_data, nbytes);
      end
      checks++;
      if (cc_match !== 1'b1 || cc_crc !== exp_crc) begin
         errors++; $display("FAIL ext_crc: got match %b crc %h want match 1 crc %h", cc_match, cc_crc, exp_crc);
      end
      checks++;
      if (gf_count !== 1 || frame_data !== 1'b1) begin
         errors++; $display("FAIL ext_frame: got %0d getframe data %b want 1 and 1", gf_count, frame_data);
      end
      repeat (3) send_bit(1'b1);
   endtask

   task automatic test_remote();
      clear_mon();
      build_frame(1'b0, 11'h0A1, 18'd0, 1'b1, 4'd3, 64'd0, 15'd0, 1'b1);
      send_range(0, fbits.size() - 1);
      checks++;
      if ({frame_data, frame_remote, frame_error, frame_overload} !== 4'b0100) begin
         errors++; $display("FAIL rtr_type: got %b want 0100", {frame_data, frame_remote, frame_error, frame_overload});
      end
      checks++;
      if (nbytes !== 4'd3 || can_data !== 64'd0) begin
         errors++; $display("FAIL rtr_fields: got dlc %0d data %h want dlc 3 data 0", nbytes, can_data);
      end
      checks++;
      if (cc_match !== 1'b1 || cc_crc !== exp_crc || cc_idx !== crc_last) begin
         errors++; $display("FAIL rtr_crc: got match %b crc %h bit %0d want 1 %h %0d", cc_match, cc_crc, cc_idx, exp_crc, crc_last);
      end
      checks++;
      if (gf_count !== 1) begin errors++; $display("FAIL rtr_getframe: got %0d want 1", gf_count); end
      repeat (3) send_bit(1'b1);
   endtask

   task automatic test_bad_crc_ack();
      clear_mon();
      build_frame(1'b0, 11'h123, 18'd0, 1'b0, 4'd2, 64'hBEEF, 15'h0001, 1'b0);
      send_range(0, fbits.size() - 8);
      checks++;
      if (cc_count !== 1 || cc_match !== 1'b0 || cc_crc !== exp_crc) begin
         errors++; $display("FAIL bad_crc: got %0d pulses match %b crc %h want 1 0 %h", cc_count, cc_match, cc_crc, exp_crc);
      end
      checks++;
      if ({ack_error, crc_error, eof_error} !== 3'b100) begin
         errors++; $display("FAIL bad_ack: got ack/crc/eof %b want 100", {ack_error, crc_error, eof_error});
      end
      checks++;
      if (gf_count !== 0) begin errors++; $display("FAIL bad_nogf: got %0d getframe want 0", gf_count); end
      fbits.delete();
      push(64'd0, 6); push(64'hFF, 8);
      send_range(0, 13);
      checks++;
      if ({frame_data, frame_remote, frame_error, frame_overload} !== 4'b0010 || gf_count !== 1) begin
         errors++; $display("FAIL bad_errframe: got type %b getframe %0d want 0010 1",
            {frame_data, frame_remote, frame_error, frame_overload}, gf_count);
      end
      checks++;
      if (error_type !== 1'b1 || error_frame !== 6'd0 || ack_error !== 1'b1) begin
         errors++; $display("FAIL bad_flag: got type %b flag %b ack %b want 1 000000 1", error_type, error_frame, ack_error);
      end
   endtask

   task automatic test_error_frame();
      clear_mon();
      fbits.delete();
      push(64'd0, 6); push(64'h55, 7); push(64'hFF, 8);
      send_range(0, fbits.size() - 1);
      checks++;
      if ({frame_data, frame_remote, frame_error, frame_overload} !== 4'b0010) begin
         errors++; $display("FAIL ef_type: got %b want 0010", {frame_data, frame_remote, frame_error, frame_overload});
      end
      checks++;
      if (error_type !== 1'b1 || error_flag !== 7'b1010101) begin
         errors++; $display("FAIL ef_flag: got type %b flag %b want 1 1010101", error_type, error_flag);
      end
      checks++;
      if (gf_count !== 1 || gf_idx !== 20) begin
         errors++; $display("FAIL ef_getframe: got %0d at bit %0d want 1 at bit 20", gf_count, gf_idx);
      end
   endtask

   task automatic test_overload();
      clear_mon();
      fbits.delete();
      push(64'd0, 6); push(64'hFF, 8);
      send_range(0, fbits.size() - 1);
      checks++;
      if ({frame_data, frame_remote, frame_error, frame_overload} !== 4'b0001) begin
         errors++; $display("FAIL ovl_type: got %b want 0001", {frame_data, frame_remote, frame_error, frame_overload});
      end
      checks++;
      if (overload_check !== 13'b0000011111111) begin
         errors++; $display("FAIL ovl_check: got %b want 0000011111111", overload_check);
      end
      checks++;
      if (gf_count !== 1 || gf_idx !== 13 || debug_state !== 7'd0) begin
         errors++; $display("FAIL ovl_done: got %0d at bit %0d state %0d want 1 at 13 state 0", gf_count, gf_idx, debug_state);
      end
   endtask

   task automatic test_back_to_back();
      int flen;
      clear_mon();
      build_frame(1'b0, 11'h2A5, 18'd0, 1'b0, 4'd1, 64'h5A, 15'd0, 1'b1);
      flen = fbits.size();
      push(64'd0, 6); push(64'hFF, 8);
      send_range(0, fbits.size() - 1);
      checks++;
      if (gf_count !== 2 || gf_idx !== flen + 13) begin
         errors++; $display("FAIL b2b_getframe: got %0d last at %0d want 2 last at %0d", gf_count, gf_idx, flen + 13);
      end
      checks++;
      if (frame_overload !== 1'b1 || overload_check !== 13'h00FF) begin
         errors++; $display("FAIL b2b_ovl: got %b %b want 1 0000011111111", frame_overload, overload_check);
      end
   endtask

   task automatic test_reset_midframe();
      clear_mon();
      build_frame(1'b0, 11'h551, 18'd0, 1'b0, 4'd4, 64'h1234, 15'd0, 1'b1);
      send_range(0, 19);
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (debug_state !== 7'd0 || bit_id_11 !== 11'd0 || frame_data !== 1'b0) begin
         errors++; $display("FAIL rst_mid: got state %0d id %h data %b want 0 0 0", debug_state, bit_id_11, frame_data);
      end
      @(posedge sample); #1;
      reset_n = 1'b1;
      repeat (12) send_bit(1'b1);
      checks++;
      if (gf_count !== 0) begin errors++; $display("FAIL rst_nogf: got %0d getframe want 0", gf_count); end
   endtask

   initial begin
      clear_mon();
      test_reset();
      test_std_data();
      test_extended();
      test_remote();
      test_bad_crc_ack();
      test_error_frame();
      test_overload();
      test_back_to_back();
      test_reset_midframe();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
